// File: rtl/trainerror_pkg.sv
// Shared encodings for the TRAINERROR sideband controller: message codes,
// main-FSM and arbiter state types.
package trainerror_pkg;

    localparam int SB_MSG_WIDTH_DEF = 4;

    localparam logic [SB_MSG_WIDTH_DEF-1:0] TRAINERROR_ENTRY_REQ  = 4'd15;
    localparam logic [SB_MSG_WIDTH_DEF-1:0] TRAINERROR_ENTRY_RESP = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } te_state_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        GRANT_TX = 2'd1,
        GRANT_RX = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_TX = 1'b0,
        GNT_RX = 1'b1
    } gnt_e;

endpackage

// File: rtl/sb_rr_arbiter2.sv
// Two-requester round-robin owner of the single SB transmit port; a grant is
// held until the SB transmitter's busy signal falls.
module sb_rr_arbiter2
    import trainerror_pkg::*;
#(
    parameter int SB_MSG_WIDTH = SB_MSG_WIDTH_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_tx_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_tx_msg,
    input  logic                    i_rx_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_rx_msg,
    input  logic                    i_sb_busy,
    output logic                    o_sb_valid,
    output logic [SB_MSG_WIDTH-1:0] o_sb_msg,
    output logic                    o_falling_edge_busy,
    output logic                    o_tx_pending
);

    arb_state_e arb_q;
    gnt_e       last_grant_q;
    logic       busy_d;
    logic       pick_tx;

    assign o_falling_edge_busy = busy_d & ~i_sb_busy;
    assign pick_tx             = i_tx_valid & (~i_rx_valid | (last_grant_q == GNT_RX));
    assign o_tx_pending        = (arb_q == GRANT_TX) | ((arb_q == ARB_IDLE) & i_tx_valid);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            arb_q        <= ARB_IDLE;
            last_grant_q <= GNT_RX;
            o_sb_valid   <= 1'b0;
            o_sb_msg     <= '0;
            busy_d       <= 1'b0;
        end else begin
            busy_d <= i_sb_busy;
            if (!i_en) begin
                arb_q      <= ARB_IDLE;
                o_sb_valid <= 1'b0;
                o_sb_msg   <= '0;
            end else begin
                case (arb_q)
                    ARB_IDLE: begin
                        if (!i_sb_busy && (i_tx_valid || i_rx_valid)) begin
                            o_sb_valid <= 1'b1;
                            if (pick_tx) begin
                                arb_q        <= GRANT_TX;
                                o_sb_msg     <= i_tx_msg;
                                last_grant_q <= GNT_TX;
                            end else begin
                                arb_q        <= GRANT_RX;
                                o_sb_msg     <= i_rx_msg;
                                last_grant_q <= GNT_RX;
                            end
                        end
                    end
                    // The message is already with SB, so a dropped requester
                    // valid does not end the grant; only the busy fall does.
                    GRANT_TX, GRANT_RX: begin
                        if (o_falling_edge_busy) begin
                            arb_q      <= ARB_IDLE;
                            o_sb_valid <= 1'b0;
                        end
                    end
                    default: begin
                        arb_q      <= ARB_IDLE;
                        o_sb_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/trainerror_sb_ctrl.sv
// TRAINERROR sequencing: enables the TX/RX handlers, times out the handshake
// and shares the SB port between them via sb_rr_arbiter2.
//   state      | meaning
//   ST_IDLE    | waiting for LTSM request
//   ST_ACTIVE  | handlers enabled, timeout counter running
//   ST_DONE    | both handlers ended, done reported
//   ST_TIMEOUT | handlers disabled, timeout reported
module trainerror_sb_ctrl
    import trainerror_pkg::*;
#(
    parameter int                   SB_MSG_WIDTH   = SB_MSG_WIDTH_DEF,
    parameter int                   TIMEOUT_W      = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd8000000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_trainerror_req,
    output logic                    o_trainerror_en,
    input  logic                    i_tx_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_tx_msg,
    input  logic                    i_tx_end,
    input  logic                    i_rx_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_rx_msg,
    input  logic                    i_rx_end,
    input  logic                    i_sb_busy,
    output logic                    o_sb_valid,
    output logic [SB_MSG_WIDTH-1:0] o_sb_msg,
    output logic                    o_falling_edge_busy,
    output logic                    o_tx_pending,
    output logic                    o_trainerror_done,
    output logic                    o_timeout
);

    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_CYCLES - 1'b1;

    te_state_e            state_q;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic                 arb_en;

    // Gated by the live request so a dropped request frees SB on the same edge
    // the main FSM returns to idle.
    assign arb_en = ((state_q == ST_ACTIVE) || (state_q == ST_DONE)) && i_trainerror_req;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q           <= ST_IDLE;
            cnt_q             <= '0;
            o_trainerror_en   <= 1'b0;
            o_trainerror_done <= 1'b0;
            o_timeout         <= 1'b0;
        end else if ((state_q != ST_IDLE) && !i_trainerror_req) begin
            state_q           <= ST_IDLE;
            cnt_q             <= '0;
            o_trainerror_en   <= 1'b0;
            o_trainerror_done <= 1'b0;
            o_timeout         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_trainerror_req) begin
                        state_q         <= ST_ACTIVE;
                        cnt_q           <= '0;
                        o_trainerror_en <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (i_tx_end && i_rx_end) begin
                        state_q           <= ST_DONE;
                        o_trainerror_done <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q         <= ST_TIMEOUT;
                        o_trainerror_en <= 1'b0;
                        o_timeout       <= 1'b1;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE, ST_TIMEOUT: begin
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    sb_rr_arbiter2 #(
        .SB_MSG_WIDTH(SB_MSG_WIDTH)
    ) u_arb (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_en               (arb_en),
        .i_tx_valid         (i_tx_valid),
        .i_tx_msg           (i_tx_msg),
        .i_rx_valid         (i_rx_valid),
        .i_rx_msg           (i_rx_msg),
        .i_sb_busy          (i_sb_busy),
        .o_sb_valid         (o_sb_valid),
        .o_sb_msg           (o_sb_msg),
        .o_falling_edge_busy(o_falling_edge_busy),
        .o_tx_pending       (o_tx_pending)
    );

endmodule

// File: tb/tb_trainerror_sb_ctrl.sv
// Directed bench for trainerror_sb_ctrl: arbitration vector table plus
// hand-written reset, handshake, done and timeout sequences.
module tb_trainerror_sb_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       tv = 1'b0, rv = 1'b0, tend = 1'b0, rend = 1'b0, busy = 1'b0;
    logic [3:0] tmsg = 4'd0, rmsg = 4'd0;
    logic       en, sb_valid, fall, pend, done, tout;
    logic [3:0] sb_msg;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    trainerror_sb_ctrl #(
        .SB_MSG_WIDTH  (4),
        .TIMEOUT_W     (24),
        .TIMEOUT_CYCLES(24'd16)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_trainerror_req   (req),
        .o_trainerror_en    (en),
        .i_tx_valid         (tv),
        .i_tx_msg           (tmsg),
        .i_tx_end           (tend),
        .i_rx_valid         (rv),
        .i_rx_msg           (rmsg),
        .i_rx_end           (rend),
        .i_sb_busy          (busy),
        .o_sb_valid         (sb_valid),
        .o_sb_msg           (sb_msg),
        .o_falling_edge_busy(fall),
        .o_tx_pending       (pend),
        .o_trainerror_done  (done),
        .o_timeout          (tout)
    );

    typedef struct {
        logic       tv;
        logic [3:0] tm;
        logic       rv;
        logic [3:0] rm;
        logic       busy;
        logic       exp_valid;
        logic [3:0] exp_msg;
        logic       exp_pend;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " en"}, en, 0);
        chk({tag, " sb_valid"}, sb_valid, 0);
        chk({tag, " sb_msg"}, sb_msg, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " timeout"}, tout, 0);
    endtask

    initial begin
        //            tv    tm     rv    rm     busy  valid msg    pend
        vecs[0] = '{1'b1, 4'd15, 1'b0, 4'd0,  1'b0, 1'b1, 4'd15, 1'b1};
        vecs[1] = '{1'b0, 4'd0,  1'b1, 4'd14, 1'b0, 1'b1, 4'd14, 1'b0};
        vecs[2] = '{1'b1, 4'd3,  1'b1, 4'd5,  1'b0, 1'b1, 4'd3,  1'b1};
        vecs[3] = '{1'b1, 4'd7,  1'b1, 4'd9,  1'b0, 1'b1, 4'd9,  1'b1};
        vecs[4] = '{1'b1, 4'd2,  1'b1, 4'd4,  1'b1, 1'b0, 4'd0,  1'b1};
        vecs[5] = '{1'b1, 4'd8,  1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  1'b1};
        vecs[6] = '{1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  1'b0};
        vecs[7] = '{1'b0, 4'd0,  1'b1, 4'd6,  1'b0, 1'b1, 4'd6,  1'b0};
        vecs[8] = '{1'b1, 4'd1,  1'b1, 4'd2,  1'b0, 1'b1, 4'd1,  1'b1};

        // Reset values, then asynchronous reset in the middle of a grant
        #12;
        chk_quiet("reset");
        chk("reset fall", fall, 0);
        chk("reset pend", pend, 0);
        rst_n = 1'b1;
        tick();
        req = 1'b1; tv = 1'b1; tmsg = 4'd15;
        tick();
        tick();
        chk("pre-reset sb_valid", sb_valid, 1);
        #3;
        rst_n = 1'b0; tv = 1'b0; req = 1'b0;
        #1;
        chk_quiet("async reset");
        chk("async reset pend", pend, 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("post-reset idle en", en, 0);

        // First tie after reset goes to TX, RX follows one cycle after the strobe
        req = 1'b1; tv = 1'b1; tmsg = 4'd15; rv = 1'b1; rmsg = 4'd14;
        tick();
        chk("tie en", en, 1);
        chk("tie no grant yet", sb_valid, 0);
        tick();
        chk("tie tx valid", sb_valid, 1);
        chk("tie tx msg", sb_msg, 15);
        chk("tie tx pend", pend, 1);
        tv = 1'b0; busy = 1'b1;
        #1;
        chk("tie pend after tx drop", pend, 1);
        tick();
        chk("tie pend busy", pend, 1);
        chk("tie msg stable", sb_msg, 15);
        busy = 1'b0;
        #1;
        chk("tie strobe", fall, 1);
        chk("tie pend strobe", pend, 1);
        tick();
        chk("tie released", sb_valid, 0);
        chk("tie pend idle", pend, 0);
        tick();
        chk("tie rx valid", sb_valid, 1);
        chk("tie rx msg", sb_msg, 14);
        chk("tie rx pend", pend, 0);
        rv = 1'b0; busy = 1'b1;
        tick();
        busy = 1'b0;
        tick();
        req = 1'b0;
        tick();

        // Single TX message, busy for 3 cycles, strobe, re-grant one cycle later
        req = 1'b1; tv = 1'b1; tmsg = 4'd15;
        tick();
        chk("hs en", en, 1);
        chk("hs no grant", sb_valid, 0);
        tick();
        chk("hs valid", sb_valid, 1);
        chk("hs msg", sb_msg, 15);
        busy = 1'b1;
        tick();
        tick();
        tick();
        chk("hs hold valid", sb_valid, 1);
        chk("hs no strobe busy", fall, 0);
        busy = 1'b0;
        #1;
        chk("hs strobe", fall, 1);
        chk("hs valid in strobe", sb_valid, 1);
        tick();
        chk("hs valid dropped", sb_valid, 0);
        chk("hs strobe width", fall, 0);
        tick();
        chk("hs re-grant", sb_valid, 1);
        req = 1'b0; tv = 1'b0;
        tick();
        chk_quiet("hs drop req");

        // Arbitration vector table, run from DONE with the arbiter idle
        req = 1'b1; tend = 1'b1; rend = 1'b1;
        tick();
        tick();
        chk("table done", done, 1);
        for (int i = 0; i < 9; i++) begin
            tv = vecs[i].tv; tmsg = vecs[i].tm;
            rv = vecs[i].rv; rmsg = vecs[i].rm;
            busy = vecs[i].busy;
            #1;
            chk($sformatf("vec%0d pend", i), pend, vecs[i].exp_pend);
            tick();
            chk($sformatf("vec%0d valid", i), sb_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d msg", i), sb_msg, vecs[i].exp_msg);
            tv = 1'b0; rv = 1'b0;
            if (vecs[i].exp_valid) begin
                busy = 1'b1;
                tick();
                busy = 1'b0;
                #1;
                chk($sformatf("vec%0d strobe", i), fall, 1);
                tick();
                chk($sformatf("vec%0d release", i), sb_valid, 0);
            end else begin
                busy = 1'b0;
                tick();
            end
        end
        req = 1'b0; tend = 1'b0; rend = 1'b0;
        tick();

        // Done at ACTIVE cycle 10, then request dropped mid-transfer
        req = 1'b1;
        tick();
        for (int c = 1; c <= 10; c++) tick();
        chk("done c10", done, 0);
        tend = 1'b1; rend = 1'b1;
        tick();
        chk("done c11", done, 1);
        chk("done c11 en", en, 1);
        chk("done c11 timeout", tout, 0);
        tv = 1'b1; tmsg = 4'd14;
        tick();
        chk("done grant", sb_valid, 1);
        req = 1'b0; tv = 1'b0;
        tick();
        chk_quiet("done drop req");
        tend = 1'b0; rend = 1'b0;

        // Timeout exactly 16 cycles after entering ACTIVE
        req = 1'b1;
        tick();
        chk("to c0 en", en, 1);
        for (int c = 1; c <= 15; c++) tick();
        chk("to c15 timeout", tout, 0);
        chk("to c15 en", en, 1);
        tick();
        chk("to c16 timeout", tout, 1);
        chk("to c16 en", en, 0);
        chk("to c16 done", done, 0);
        tick();
        chk("to hold", tout, 1);
        req = 1'b0;
        tick();
        chk("to cleared", tout, 0);

        // Ends on cycle 15: done wins over timeout
        req = 1'b1;
        tick();
        for (int c = 1; c <= 15; c++) tick();
        tend = 1'b1; rend = 1'b1;
        tick();
        chk("race done", done, 1);
        chk("race timeout", tout, 0);
        chk("race en", en, 1);
        tick();
        chk("race timeout later", tout, 0);
        req = 1'b0; tend = 1'b0; rend = 1'b0;
        tick();
        chk_quiet("final idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
